// File: rtl/ccg_bench_pkg.sv
// Shared definitions for the combinational-benchmark sweep block.
//
// Contents:
//   DefNIn / DefNOut   default stimulus and response widths
//   DefPoly / DefSeed  default MISR feedback polynomial and initial value
//   sweep_state_e      sweep controller state encoding (IDLE, RUN, DRAIN, DONE)
//   state_is_busy()    true while a sweep is in flight (RUN or DRAIN)
package ccg_bench_pkg;

  localparam int unsigned DefNIn  = 6;
  localparam int unsigned DefNOut = 16;

  localparam logic [15:0] DefPoly = 16'h1021;
  localparam logic [15:0] DefSeed = 16'h0000;

  // Plain localparam encoding keeps the state values visible to older tools.
  typedef logic [1:0] sweep_state_e;

  localparam sweep_state_e StIdle  = 2'd0;
  localparam sweep_state_e StRun   = 2'd1;
  localparam sweep_state_e StDrain = 2'd2;
  localparam sweep_state_e StDone  = 2'd3;

  function automatic logic state_is_busy(input sweep_state_e st);
    return (st == StRun) || (st == StDrain);
  endfunction

endpackage

// File: rtl/misr_n.sv
// Multiple-input signature register, N_OUT bits wide.
//
// Each enabled cycle folds d into the register:
//   q_next = (q << 1) ^ (q[MSB] ? POLY : 0) ^ d   (carry out of the MSB dropped)
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, loads SEED
//   clr  synchronous clear, loads SEED; takes priority over en
//   en   fold d into the signature this cycle
//   d    parallel data input
//   q    current signature
module misr_n
  import ccg_bench_pkg::*;
#(
  parameter int unsigned      N_OUT = DefNOut,
  parameter logic [N_OUT-1:0] POLY  = DefPoly,
  parameter logic [N_OUT-1:0] SEED  = DefSeed
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [N_OUT-1:0] d,
  output logic [N_OUT-1:0] q
);

  logic [N_OUT-1:0] sig_q;
  logic [N_OUT-1:0] sig_d;
  logic [N_OUT-1:0] sig_step;

  always_comb begin
    // The shift stays N_OUT bits wide, so the old MSB is discarded here and
    // re-enters only through the polynomial feedback term.
    sig_step = (sig_q << 1) ^ (sig_q[N_OUT-1] ? POLY : '0) ^ d;

    sig_d = sig_q;
    if (clr) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = sig_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign q = sig_q;

endmodule

// File: rtl/vec_sweep_misr.sv
// Exhaustive input sweep of a combinational benchmark with MISR compaction.
//
// A start request walks x through every value 0 .. 2^N_IN-1, one per cycle.
// The benchmark response f is registered into f_q and then folded into a MISR,
// so f never reaches an output except through the signature register. After
// the last vector one DRAIN cycle folds the final response, then DONE holds
// the signature and compares it against golden_sig.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       begin a sweep (accepted in IDLE or DONE only)
//   abort       cancel any sweep and return to IDLE; wins over start
//   x           stimulus vector to the benchmark (0 outside RUN)
//   f           benchmark response, combinational from x
//   golden_sig  expected signature, held stable during a sweep
//   busy        high in RUN or DRAIN
//   done        one-cycle pulse on entry to DONE
//   sig         current MISR contents
//   pass        sig == golden_sig while in DONE, else 0
module vec_sweep_misr
  import ccg_bench_pkg::*;
#(
  parameter int unsigned      N_IN  = DefNIn,
  parameter int unsigned      N_OUT = DefNOut,
  parameter logic [N_OUT-1:0] POLY  = DefPoly,
  parameter logic [N_OUT-1:0] SEED  = DefSeed
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  x,
  input  logic [N_OUT-1:0] f,
  input  logic [N_OUT-1:0] golden_sig,
  output logic             busy,
  output logic             done,
  output logic [N_OUT-1:0] sig,
  output logic             pass
);

  localparam logic [N_IN-1:0] CntMax = '1;

  sweep_state_e     state_q, state_d;
  logic [N_IN-1:0]  cnt_q, cnt_d;
  logic [N_OUT-1:0] f_q, f_d;
  logic             done_q, done_d;

  logic             misr_clr;
  logic             misr_en;
  logic [N_OUT-1:0] misr_sig;

  // Next-state and MISR control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f_d      = f_q;
    done_d   = 1'b0;
    misr_clr = 1'b0;
    misr_en  = 1'b0;

    if (abort) begin
      // Abort from any state lands in IDLE with a fresh signature.
      state_d  = StIdle;
      cnt_d    = '0;
      f_d      = '0;
      misr_clr = 1'b1;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d  = StRun;
            cnt_d    = '0;
            f_d      = '0;
            misr_clr = 1'b1;
          end
        end
        StRun: begin
          f_d = f;
          // f_q holds nothing useful during the first RUN cycle, so the
          // fold starts one cycle late and DRAIN supplies the final fold.
          misr_en = (cnt_q != '0);
          if (cnt_q == CntMax) begin
            state_d = StDrain;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDrain: begin
          misr_en = 1'b1;
          state_d = StDone;
          done_d  = 1'b1;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      f_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      done_q  <= done_d;
    end
  end

  misr_n #(
    .N_OUT (N_OUT),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (misr_clr),
    .en  (misr_en),
    .d   (f_q),
    .q   (misr_sig)
  );

  // Outputs decode registered state only; f has no path here.
  assign x    = (state_q == StRun) ? cnt_q : '0;
  assign busy = state_is_busy(state_q);
  assign done = done_q;
  assign sig  = misr_sig;
  assign pass = (state_q == StDone) && (misr_sig == golden_sig);

endmodule

// File: tb/tb_vec_sweep_misr.sv
// Self-checking bench for vec_sweep_misr with default parameters.
// The benchmark is a random 64-entry response table; the expected signature
// is computed by polynomial division over the whole table in vector order.
module tb_vec_sweep_misr;

  localparam logic [15:0] Seed = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [5:0]  x;
  logic [15:0] f;
  logic [15:0] golden_sig;
  logic        busy;
  logic        done;
  logic [15:0] sig;
  logic        pass;

  logic [15:0] resp [64];

  int checks   = 0;
  int failures = 0;

  // Observations gathered by do_sweep for the calling test to judge.
  int          obs_done_cyc;
  int          obs_busy_bad;
  int          obs_run_bad;
  int          obs_after_bad;
  logic [15:0] obs_sig;
  logic        obs_pass;

  always #5 clk = ~clk;

  always_comb f = resp[x];

  vec_sweep_misr dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .x          (x),
    .f          (f),
    .golden_sig (golden_sig),
    .busy       (busy),
    .done       (done),
    .sig        (sig),
    .pass       (pass)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Signature of the whole table: multiply by x modulo x^16+x^12+x^5+1, add response.
  function automatic logic [15:0] model_sig();
    logic [16:0] acc;
    logic [15:0] s;
    s = Seed;
    for (int i = 0; i < 64; i++) begin
      acc = {s, 1'b0};
      if (acc[16]) acc = acc ^ 17'h11021;
      s = acc[15:0] ^ resp[i];
    end
    return s;
  endfunction

  task automatic fill_resp(input int mode);
    for (int i = 0; i < 64; i++) begin
      resp[i] = (mode == 0) ? 16'h0000 : 16'($urandom);
    end
  endtask

  // Pulse start now (cycle T) and follow the sweep; cycle k is sampled after edge k.
  task automatic do_sweep();
    int exp_x;
    obs_done_cyc  = -1;
    obs_busy_bad  = 0;
    obs_run_bad   = 0;
    obs_after_bad = 0;
    obs_sig       = 'x;
    obs_pass      = 1'bx;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      if (k > 1) tick();
      if (busy !== 1'(k <= 65)) obs_busy_bad++;
      exp_x = (k <= 64) ? k - 1 : 0;
      if (x !== 6'(exp_x)) obs_run_bad++;
      if (k < 66 && (pass !== 1'b0 || done !== 1'b0)) obs_run_bad++;
      if (done === 1'b1) begin
        obs_done_cyc = k;
        obs_sig      = sig;
        obs_pass     = pass;
        break;
      end
    end
    if (obs_done_cyc >= 0) begin
      tick();
      if (done !== 1'b0 || sig !== obs_sig || pass !== obs_pass || busy !== 1'b0)
        obs_after_bad++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; golden_sig = 16'h0000;
    fill_resp(0);
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, pass} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got busy/done/pass=%b want 000", {busy, done, pass});
    end
    checks++;
    if (x !== 6'd0) begin
      failures++;
      $display("FAIL reset_x got %0d want 0", x);
    end
    checks++;
    if (sig !== Seed) begin
      failures++;
      $display("FAIL reset_sig got %h want %h", sig, Seed);
    end
  endtask

  task automatic check_sweep(input string name, input logic [15:0] exp_sig,
                             input logic exp_pass);
    checks++;
    if (obs_done_cyc != 66) begin
      failures++;
      $display("FAIL %s done_cycle got %0d want 66", name, obs_done_cyc);
    end
    checks++;
    if (obs_busy_bad != 0 || obs_run_bad != 0 || obs_after_bad != 0) begin
      failures++;
      $display("FAIL %s sequence busy_err=%0d run_err=%0d after_err=%0d want 0/0/0",
               name, obs_busy_bad, obs_run_bad, obs_after_bad);
    end
    checks++;
    if (obs_sig !== exp_sig) begin
      failures++;
      $display("FAIL %s sig got %h want %h", name, obs_sig, exp_sig);
    end
    checks++;
    if (obs_pass !== exp_pass) begin
      failures++;
      $display("FAIL %s pass got %b want %b", name, obs_pass, exp_pass);
    end
  endtask

  task automatic test_zero_response();
    fill_resp(0);
    golden_sig = 16'h0000;
    do_sweep();
    check_sweep("zero", 16'h0000, 1'b1);
  endtask

  task automatic test_single_bits();
    fill_resp(0);
    resp[63]   = 16'h0001;
    golden_sig = 16'h0002;
    do_sweep();
    check_sweep("last_vec", 16'h0001, 1'b0);
    fill_resp(0);
    resp[62] = 16'h0001;
    do_sweep();
    check_sweep("penult_vec", 16'h0002, 1'b1);
  endtask

  task automatic test_random_sweeps();
    logic [15:0] exp;
    for (int n = 0; n < 4; n++) begin
      fill_resp(1);
      exp = model_sig();
      golden_sig = (n % 2 == 0) ? exp : exp ^ (16'h0001 << $urandom_range(15, 0));
      do_sweep();
      check_sweep("random", exp, 1'(n % 2 == 0));
    end
  endtask

  task automatic test_start_ignored();
    int done_at;
    fill_resp(1);
    golden_sig = model_sig();
    done_at = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      if (k > 1) tick();
      start = (k == 10 || k == 65) ? 1'b1 : 1'b0;
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (done_at != 66 || sig !== golden_sig) begin
      failures++;
      $display("FAIL start_ignored done_cycle=%0d sig=%h want 66 sig=%h",
               done_at, sig, golden_sig);
    end
  endtask

  task automatic test_abort();
    logic [15:0] exp;
    fill_resp(1);
    exp = model_sig();
    golden_sig = exp;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 20; k++) tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if ({busy, done, pass} !== 3'b000 || x !== 6'd0 || sig !== Seed) begin
      failures++;
      $display("FAIL abort_run got busy/done/pass=%b x=%0d sig=%h want 000 x=0 sig=%h",
               {busy, done, pass}, x, sig, Seed);
    end
    do_sweep();
    check_sweep("after_abort", exp, 1'b1);
    // Abort together with start while in DONE must drop to IDLE.
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || pass !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_done got busy=%b pass=%b done=%b want 0 0 0", busy, pass, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    logic [15:0] first_sig;
    fill_resp(1);
    exp = model_sig();
    golden_sig = exp;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 40; k++) tick();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    checks++;
    if ({busy, done, pass} !== 3'b000 || x !== 6'd0 || sig !== Seed) begin
      failures++;
      $display("FAIL reset_mid got busy/done/pass=%b x=%0d sig=%h want 000 x=0 sig=%h",
               {busy, done, pass}, x, sig, Seed);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_start got busy=%b want 0", busy);
    end
    do_sweep();
    check_sweep("b2b_first", exp, 1'b1);
    first_sig = obs_sig;
    do_sweep();
    check_sweep("b2b_second", exp, 1'b1);
    checks++;
    if (obs_sig !== first_sig) begin
      failures++;
      $display("FAIL b2b_repeat got %h want %h", obs_sig, first_sig);
    end
  endtask

  initial begin
    test_reset();
    test_zero_response();
    test_single_bits();
    test_random_sweeps();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_sweep_misr.md
VEC_SWEEP_MISR -- requirements
Module: vec_sweep_misr

Interface
REQ-001 SHALL have parameter N_IN, default 6: width of the stimulus vector driven to the combinational benchmark.
REQ-002 SHALL have parameter N_OUT, default 16: width of the response vector consumed from the benchmark.
REQ-003 SHALL have parameter POLY, default 16'h1021: MISR feedback polynomial, N_OUT bits.
REQ-004 SHALL have parameter SEED, default 16'h0000: MISR initial value.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: request a full sweep; sampled only in IDLE or DONE.
REQ-008 SHALL have port abort, input, 1 bit: cancel a sweep in progress.
REQ-009 SHALL have port x, output, N_IN bits: stimulus, bit i drives benchmark input x<i>.
REQ-010 SHALL have port f, input, N_OUT bits: response, bit j-1 is benchmark output f<j>; purely combinational from x.
REQ-011 SHALL have port golden_sig, input, N_OUT bits: expected signature, static during a sweep.
REQ-012 SHALL have port busy, output, 1 bit: high in RUN or DRAIN.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse on entry to DONE.
REQ-014 SHALL have port sig, output, N_OUT bits: current MISR contents.
REQ-015 SHALL have port pass, output, 1 bit: sig == golden_sig, qualified by DONE state; 0 elsewhere.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE/DONE plus start SHALL load cnt=0, MISR=SEED, f_q=0, and go to RUN.
REQ-018 x SHALL equal cnt (registered, no glitch path from f); x=0 outside RUN.
REQ-019 Each RUN cycle SHALL capture f into f_q, fold the previous f_q into the MISR (except the first RUN cycle), and increment cnt.
REQ-020 MISR step SHALL be sig_next = (sig<<1) XOR (sig[MSB] ? POLY : 0) XOR f_q, all N_OUT bits wide, carry discarded.
REQ-021 cnt == 2^N_IN-1 in RUN SHALL capture the last f and go to DRAIN; cnt SHALL not wrap.
REQ-022 DRAIN SHALL fold the last f_q, go to DONE, and pulse done.
REQ-023 Sweep latency: start cycle T, RUN from T+1 to T+64, DRAIN at T+65, done high at T+66 (N_IN=6); exactly 64 folds.
REQ-024 DONE SHALL hold sig and pass until the next start; start in DONE restarts per REQ-017.
REQ-025 start in RUN or DRAIN SHALL be ignored.
REQ-026 abort in RUN or DRAIN SHALL go to IDLE next cycle with no done pulse, sig=SEED, and x=0; abort SHALL win over simultaneous start.
REQ-027 abort in IDLE or DONE SHALL go to IDLE, clearing pass.

Reset
REQ-028 rst SHALL force state=IDLE, cnt=0, x=0, f_q=0, sig=SEED, busy=0, done=0, and pass=0 on the next edge, overriding start and abort, including mid-sweep.

Structure
REQ-029 The state enum, POLY/SEED defaults, and N_IN/N_OUT defaults SHALL live in shared package ccg_bench_pkg.
REQ-030 The MISR SHALL be a separate sub-module, misr_n (parameters N_OUT, POLY, SEED; ports clk, rst, clr, en, d, q).
REQ-031 The block SHALL contain no combinational path from f to any output except through the MISR register.

Verification
REQ-032 f tied to 0, SEED=0, golden_sig=0, start pulse -> done at T+66, sig=16'h0000, pass=1, busy high T+1..T+65.
REQ-033 f=16'h0001 only when x=63, otherwise 0 -> sig=16'h0001 at DONE; with golden_sig=16'h0002, pass=0.
REQ-034 f=16'h0001 only when x=62 -> sig=16'h0002; x sequence 0..63 monotonic, one value per cycle.
REQ-035 abort at T+20 -> IDLE at T+21, no done pulse, x=0, sig=SEED; start at T+21 restarts a full 66-cycle sweep.
REQ-036 rst at T+40 together with start -> IDLE, all outputs at reset values; a start in DONE immediately re-runs and yields an identical sig.
